// File: rtl/spartan_arb2.sv
// spartan_arb2: two-master to one-slave Spartan bus arbiter.
// Grants whole packets (SOP..EOP) to one master at a time and records the
// granted master ID in a small FIFO so responses are steered back in order.
// Build option: define SPARTAN_ARB2_FIXED_PRI_EN to let master 0 always win
// simultaneous requests (no round-robin pointer); undefined gives round-robin.
//
// Handshake: a beat transfers on a rising CLK edge where VLD and RDY are both
// high. VLD never waits on RDY of the same interface; the RDY outputs here are
// combinational from the downstream RDY of the currently selected path.
module spartan_arb2 #(
   parameter int BWIDTH      = 64,
   parameter int OUTSTANDING = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [BWIDTH+1:0] SpMBUS_0,
   input  logic              SpMVLD_0,
   output logic              SpMRDY_0,
   output logic [BWIDTH+1:0] SpSBUS_0,
   output logic              SpSVLD_0,
   input  logic              SpSRDY_0,
   input  logic [BWIDTH+1:0] SpMBUS_1,
   input  logic              SpMVLD_1,
   output logic              SpMRDY_1,
   output logic [BWIDTH+1:0] SpSBUS_1,
   output logic              SpSVLD_1,
   input  logic              SpSRDY_1,
   output logic [BWIDTH+1:0] SpMBUS_S,
   output logic              SpMVLD_S,
   input  logic              SpMRDY_S,
   input  logic [BWIDTH+1:0] SpSBUS_S,
   input  logic              SpSVLD_S,
   output logic              SpSRDY_S,
   output logic              ARB_ERR
);

   localparam int SOP_BIT = BWIDTH + 1;
   localparam int EOP_BIT = BWIDTH;
   localparam int PW      = $clog2(OUTSTANDING);
   localparam int CW      = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          state;
   logic            id_mem [OUTSTANDING];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            arb_err;
`ifndef SPARTAN_ARB2_FIXED_PRI_EN
   logic            rr_ptr;
`endif

   logic cand_0, cand_1;
   logic fifo_full, fifo_empty;
   logic grant, grant_id;
   logic req_eop_hs;
   logic head_id;
   logic pop;
   logic err_set;

   // Only a beat carrying SOP can open a packet; mid-packet VLD in IDLE is held off.
   assign cand_0     = SpMVLD_0 & SpMBUS_0[SOP_BIT];
   assign cand_1     = SpMVLD_1 & SpMBUS_1[SOP_BIT];
   // Full uses the registered count, so a pop this cycle unblocks grants next cycle.
   assign fifo_full  = (count == CW'(OUTSTANDING));
   assign fifo_empty = (count == '0);
   assign grant      = (state == IDLE) & ~fifo_full & (cand_0 | cand_1);
`ifdef SPARTAN_ARB2_FIXED_PRI_EN
   assign grant_id   = ~cand_0;
`else
   assign grant_id   = (cand_0 & cand_1) ? rr_ptr : ~cand_0;
`endif

   assign head_id    = id_mem[rd_ptr];
   assign req_eop_hs = SpMVLD_S & SpMRDY_S & SpMBUS_S[EOP_BIT];
   assign pop        = ~fifo_empty & SpSVLD_S & SpSRDY_S & SpSBUS_S[EOP_BIT];
   assign err_set    = fifo_empty & SpSVLD_S;
   assign ARB_ERR    = arb_err;

   // Request path: pass the granted master straight through; everything else idles at 0.
   always_comb begin
      SpMBUS_S = '0;
      SpMVLD_S = 1'b0;
      SpMRDY_0 = 1'b0;
      SpMRDY_1 = 1'b0;
      case (state)
         GNT0: begin
            SpMBUS_S = SpMBUS_0;
            SpMVLD_S = SpMVLD_0;
            SpMRDY_0 = SpMRDY_S;
         end
         GNT1: begin
            SpMBUS_S = SpMBUS_1;
            SpMVLD_S = SpMVLD_1;
            SpMRDY_1 = SpMRDY_S;
         end
         default: ;
      endcase
   end

   // Response path: the FIFO head picks the destination; with nothing outstanding, drain.
   always_comb begin
      SpSBUS_0 = '0;
      SpSVLD_0 = 1'b0;
      SpSBUS_1 = '0;
      SpSVLD_1 = 1'b0;
      SpSRDY_S = 1'b0;
      if (fifo_empty) begin
         // RST gating keeps the drain ready low while reset is held.
         SpSRDY_S = RST & SpSVLD_S;
      end else if (head_id) begin
         SpSBUS_1 = SpSBUS_S;
         SpSVLD_1 = SpSVLD_S;
         SpSRDY_S = SpSRDY_1;
      end else begin
         SpSBUS_0 = SpSBUS_S;
         SpSVLD_0 = SpSVLD_S;
         SpSRDY_S = SpSRDY_0;
      end
   end

   // Grant FSM, round-robin pointer, ID FIFO bookkeeping and sticky error flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         arb_err <= 1'b0;
`ifndef SPARTAN_ARB2_FIXED_PRI_EN
         rr_ptr  <= 1'b0;
`endif
         for (int i = 0; i < OUTSTANDING; i++) id_mem[i] <= 1'b0;
      end else begin
         case (state)
            IDLE:       if (grant) state <= grant_id ? GNT1 : GNT0;
            GNT0, GNT1: if (req_eop_hs) state <= IDLE;
            default:    state <= IDLE;
         endcase
`ifndef SPARTAN_ARB2_FIXED_PRI_EN
         if (grant && cand_0 && cand_1) rr_ptr <= ~rr_ptr;
`endif
         if (grant) begin
            id_mem[wr_ptr] <= grant_id;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (grant && !pop)      count <= count + 1'b1;
         else if (!grant && pop) count <= count - 1'b1;
         if (err_set) arb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spartan_arb2.sv
// tb_spartan_arb2: directed bench for spartan_arb2 with queue-based scoreboard.
// Expected request beats and response deliveries are queued by the stimulus;
// two negedge monitors pop and compare on every handshake.
module tb_spartan_arb2;

   localparam int BWIDTH = 64;
   localparam int W      = BWIDTH + 2;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic [W-1:0] SpMBUS_0 = '0, SpMBUS_1 = '0, SpSBUS_S = '0;
   logic         SpMVLD_0 = 1'b0, SpMVLD_1 = 1'b0, SpSVLD_S = 1'b0;
   logic         SpSRDY_0 = 1'b1, SpSRDY_1 = 1'b1, SpMRDY_S = 1'b1;
   logic [W-1:0] SpSBUS_0, SpSBUS_1, SpMBUS_S;
   logic         SpMRDY_0, SpMRDY_1, SpSVLD_0, SpSVLD_1, SpMVLD_S, SpSRDY_S, ARB_ERR;

   spartan_arb2 #(.BWIDTH(BWIDTH), .OUTSTANDING(4)) dut (
      .CLK(CLK), .RST(RST),
      .SpMBUS_0(SpMBUS_0), .SpMVLD_0(SpMVLD_0), .SpMRDY_0(SpMRDY_0),
      .SpSBUS_0(SpSBUS_0), .SpSVLD_0(SpSVLD_0), .SpSRDY_0(SpSRDY_0),
      .SpMBUS_1(SpMBUS_1), .SpMVLD_1(SpMVLD_1), .SpMRDY_1(SpMRDY_1),
      .SpSBUS_1(SpSBUS_1), .SpSVLD_1(SpSVLD_1), .SpSRDY_1(SpSRDY_1),
      .SpMBUS_S(SpMBUS_S), .SpMVLD_S(SpMVLD_S), .SpMRDY_S(SpMRDY_S),
      .SpSBUS_S(SpSBUS_S), .SpSVLD_S(SpSVLD_S), .SpSRDY_S(SpSRDY_S),
      .ARB_ERR(ARB_ERR)
   );

   // clock
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int req_beats_seen = 0;
   int req_pkts_seen  = 0;
   // entries: {to_master1, to_master0, bus}
   logic [W+1:0] exp_req_q[$];
   logic [W+1:0] exp_rsp_q[$];

   task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_beat(input int id, input int tag, input int idx, input int n);
      logic [BWIDTH-1:0] d;
      d = {32'hC0DE_0000 | 32'(id), 16'(tag), 16'(idx)};
      return {idx == 0, idx == n - 1, d};
   endfunction

   function automatic logic [W-1:0] mk_rsp(input int tag);
      logic [BWIDTH-1:0] d;
      d = 64'hBEEF_0000_0000_0000 | 64'(tag);
      return {1'b1, 1'b1, d};
   endfunction

   task automatic exp_req(input int id, input int tag, input int n);
      for (int i = 0; i < n; i++) exp_req_q.push_back({id == 1, id == 0, mk_beat(id, tag, i, n)});
   endtask

   task automatic exp_rsp(input int id, input int tag);
      exp_rsp_q.push_back({id == 1, id == 0, mk_rsp(tag)});
   endtask

   // request monitor: the granted master is the one whose RDY follows SpMRDY_S
   always @(negedge CLK) begin
      if (SpMVLD_S && SpMRDY_S) begin
         logic [W+1:0] act;
         act = {SpMRDY_1, SpMRDY_0, SpMBUS_S};
         if (exp_req_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL req_unexpected: got %h expected nothing", act);
         end else begin
            check("req_beat", act, exp_req_q.pop_front());
         end
         req_beats_seen++;
         if (SpMBUS_S[W-2]) req_pkts_seen++;
      end
   end

   // response monitor: which master sees VLD, and what bus it receives
   always @(negedge CLK) begin
      if (SpSVLD_S && SpSRDY_S) begin
         logic [W+1:0] act;
         act = {SpSVLD_1, SpSVLD_0, SpSBUS_1 | SpSBUS_0};
         if (exp_rsp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got %h expected nothing", act);
         end else begin
            check("rsp_route", act, exp_rsp_q.pop_front());
         end
      end
   end

   // drivers: called at posedge+1, return at posedge+1 after the final handshake
   task automatic drive_pkt(input int id, input int tag, input int n);
      for (int i = 0; i < n; i++) begin
         int budget;
         logic hs;
         if (id == 0) begin SpMBUS_0 = mk_beat(id, tag, i, n); SpMVLD_0 = 1'b1; end
         else begin SpMBUS_1 = mk_beat(id, tag, i, n); SpMVLD_1 = 1'b1; end
         budget = 0;
         hs = 1'b0;
         while (!hs) begin
            @(negedge CLK);
            hs = (id == 0) ? SpMRDY_0 : SpMRDY_1;
            @(posedge CLK);
            #1;
            budget++;
            if (!hs && budget > 60) begin
               n_vec++;
               n_err++;
               $display("FAIL drive_timeout: master %0d beat %0d never accepted", id, i);
               if (id == 0) begin SpMVLD_0 = 1'b0; SpMBUS_0 = '0; end
               else begin SpMVLD_1 = 1'b0; SpMBUS_1 = '0; end
               return;
            end
         end
      end
      if (id == 0) begin SpMVLD_0 = 1'b0; SpMBUS_0 = '0; end
      else begin SpMVLD_1 = 1'b0; SpMBUS_1 = '0; end
   endtask

   task automatic drive_rsp(input int tag);
      int budget;
      logic hs;
      SpSBUS_S = mk_rsp(tag);
      SpSVLD_S = 1'b1;
      budget = 0;
      hs = 1'b0;
      while (!hs) begin
         @(negedge CLK);
         hs = SpSRDY_S;
         @(posedge CLK);
         #1;
         budget++;
         if (!hs && budget > 60) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: response tag %0h never accepted", tag);
            break;
         end
      end
      SpSVLD_S = 1'b0;
      SpSBUS_S = '0;
   endtask

   // wait until a monitor counter reaches target, then realign to posedge+1
   task automatic wait_req(input bit pkts, input int target, input int budget);
      int c;
      c = 0;
      forever begin
         @(negedge CLK);
         #1;
         if ((pkts ? req_pkts_seen : req_beats_seen) >= target) break;
         c++;
         if (c > budget) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_timeout: counter below %0d", target);
            break;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // reset state, with live inputs that must be ignored
      SpMBUS_0 = mk_beat(0, 1, 0, 1);
      SpMVLD_0 = 1'b1;
      SpSVLD_S = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_ctrl", {SpMRDY_0, SpMRDY_1, SpMVLD_S, SpSVLD_0, SpSVLD_1, SpSRDY_S, ARB_ERR}, 0);
      check("rst_mbus", SpMBUS_S, 0);
      check("rst_sbus", SpSBUS_0 | SpSBUS_1, 0);
      SpMVLD_0 = 1'b0;
      SpMBUS_0 = '0;
      SpSVLD_S = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // single master, 3-beat packet, one grant cycle, then one response
      exp_req(0, 'h10, 3);
      fork
         drive_pkt(0, 'h10, 3);
         begin
            @(negedge CLK);
            check("t1_grant_cycle_vld", SpMVLD_S, 0);
            check("t1_grant_cycle_rdy", SpMRDY_0, 0);
         end
      join
      exp_rsp(0, 'h11);
      drive_rsp('h11);

      // contention: 4 single-beat packets per master, responses as packets finish
      @(posedge CLK);
      #1;
      base = req_pkts_seen;
`ifdef SPARTAN_ARB2_FIXED_PRI_EN
      for (int k = 0; k < 4; k++) exp_req(0, 'h20 + k, 1);
      for (int k = 0; k < 4; k++) exp_req(1, 'h30 + k, 1);
      for (int k = 0; k < 8; k++) exp_rsp(k < 4 ? 0 : 1, 'h40 + k);
`else
      for (int k = 0; k < 4; k++) begin
         exp_req(0, 'h20 + k, 1);
         exp_req(1, 'h30 + k, 1);
      end
      for (int k = 0; k < 8; k++) exp_rsp(k % 2, 'h40 + k);
`endif
      fork
         begin for (int k = 0; k < 4; k++) drive_pkt(0, 'h20 + k, 1); end
         begin for (int k = 0; k < 4; k++) drive_pkt(1, 'h30 + k, 1); end
         begin
            for (int k = 0; k < 8; k++) begin
               wait_req(1'b1, base + k + 1, 100);
               drive_rsp('h40 + k);
            end
         end
      join

      // backpressure mid-packet with the other master waiting
      @(posedge CLK);
      #1;
      base = req_beats_seen;
      exp_req(1, 'h50, 4);
      exp_req(0, 'h51, 1);
      fork
         drive_pkt(1, 'h50, 4);
         begin
            wait_req(1'b0, base + 1, 50);
            drive_pkt(0, 'h51, 1);
         end
         begin
            wait_req(1'b0, base + 2, 50);
            SpMRDY_S = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge CLK);
               check("bp_bus_hold", SpMBUS_S, mk_beat(1, 'h50, 2, 4));
               check("bp_vld_hold", SpMVLD_S, 1);
               @(posedge CLK);
               #1;
            end
            SpMRDY_S = 1'b1;
         end
      join
      exp_rsp(1, 'h60);
      exp_rsp(0, 'h61);
      drive_rsp('h60);
      drive_rsp('h61);

      // full: four outstanding, fifth stalls until one response pops
      @(posedge CLK);
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_req(0, 'h70 + k, 1);
         drive_pkt(0, 'h70 + k, 1);
      end
      exp_req(1, 'h74, 1);
      fork
         drive_pkt(1, 'h74, 1);
         begin
            for (int c = 0; c < 4; c++) begin
               @(negedge CLK);
               check("full_stall_rdy", SpMRDY_1, 0);
               check("full_stall_vld", SpMVLD_S, 0);
               @(posedge CLK);
               #1;
            end
            exp_rsp(0, 'h80);
            SpSBUS_S = mk_rsp('h80);
            SpSVLD_S = 1'b1;
            @(negedge CLK);
            check("full_pop_rdy", SpSRDY_S, 1);
            @(posedge CLK);
            #1;
            SpSVLD_S = 1'b0;
            SpSBUS_S = '0;
            @(negedge CLK);
            check("full_no_same_cycle_grant", SpMVLD_S, 0);
            @(posedge CLK);
            #1;
            @(negedge CLK);
            check("full_grant_next", {SpMVLD_S, SpMRDY_1}, 2'b11);
         end
      join
      exp_rsp(0, 'h81);
      exp_rsp(0, 'h82);
      exp_rsp(0, 'h83);
      exp_rsp(1, 'h84);
      for (int k = 1; k < 5; k++) drive_rsp('h80 + k);

      // error: response with nothing outstanding is drained and flagged
      @(posedge CLK);
      #1;
      check("err_before", ARB_ERR, 0);
      exp_rsp_q.push_back('0);
      SpSBUS_S = mk_rsp('h90);
      SpSVLD_S = 1'b1;
      @(negedge CLK);
      check("drain_rdy", SpSRDY_S, 1);
      @(posedge CLK);
      #1;
      SpSVLD_S = 1'b0;
      SpSBUS_S = '0;
      @(negedge CLK);
      check("err_set", ARB_ERR, 1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("err_sticky", ARB_ERR, 1);

      // reset in the middle of a 3-beat packet
      @(posedge CLK);
      #1;
      exp_req_q.push_back({1'b0, 1'b1, mk_beat(0, 'hA0, 0, 3)});
      SpMBUS_0 = mk_beat(0, 'hA0, 0, 3);
      SpMVLD_0 = 1'b1;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check("rst_mid_granted", SpMRDY_0, 1);
      @(posedge CLK);
      #1;
      SpMBUS_0 = mk_beat(0, 'hA0, 1, 3);
      #2;
      RST = 1'b0;
      #1;
      check("rst_mid_ctrl", {SpMVLD_S, SpMRDY_0, SpMRDY_1, SpSRDY_S}, 0);
      check("rst_mid_mbus", SpMBUS_S, 0);
      check("rst_mid_err", ARB_ERR, 0);
      SpMVLD_0 = 1'b0;
      SpMBUS_0 = '0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      // after reset the FIFO is empty again, so the next response goes to master 1
      exp_req(1, 'hB0, 1);
      drive_pkt(1, 'hB0, 1);
      exp_rsp(1, 'hB1);
      drive_rsp('hB1);

      repeat (4) @(posedge CLK);
      @(negedge CLK);
      check("req_q_drained", exp_req_q.size(), 0);
      check("rsp_q_drained", exp_rsp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spartan_arb2.md
Name: spartan_arb2

Overview:
- Two-master to one-slave Spartan bus arbiter with packet-aware round-robin grant and in-order response routing.
- Sits directly upstream of the async gasket and drives its A-side master port: it merges two local requesters onto one Spartan channel and steers returning responses back to the originator.
- Single clock domain.

Parameters:
- BWIDTH, 64: payload width; each bus is BWIDTH+2 bits wide.
- OUTSTANDING, 4: depth of the response-routing ID FIFO (power of 2, minimum 2).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous active-low reset
- SpMBUS_0  input  BWIDTH+2  master 0 request bus
- SpMVLD_0  input  1  master 0 request valid
- SpMRDY_0  output  1  master 0 request ready
- SpSBUS_0  output  BWIDTH+2  master 0 response bus
- SpSVLD_0  output  1  master 0 response valid
- SpSRDY_0  input  1  master 0 response ready
- SpMBUS_1, SpMVLD_1, SpMRDY_1, SpSBUS_1, SpSVLD_1, SpSRDY_1: same as above, for master 1
- SpMBUS_S  output  BWIDTH+2  merged request to downstream slave
- SpMVLD_S  output  1  merged request valid
- SpMRDY_S  input  1  merged request ready
- SpSBUS_S  input  BWIDTH+2  response from slave
- SpSVLD_S  input  1  response valid
- SpSRDY_S  output  1  response ready
- ARB_ERR  output  1  sticky error: response received with no outstanding ID

Behaviour:
- Bus framing: bit BWIDTH+1 = SOP, bit BWIDTH = EOP. A single-beat packet has both bits set.
- A handshake (beat transfer) occurs when VLD and RDY are both high on a CLK rising edge.
- Reset (RST low, asynchronous):
  - FSM goes to IDLE; round-robin pointer = 0; ID FIFO empty; ARB_ERR = 0.
  - All VLD and RDY outputs = 0; all bus outputs = 0.
- FSM states and transitions:
  - IDLE, grant evaluation: a candidate is a master with VLD=1 and SOP=1; the ID FIFO must not be full.
  - IDLE, one candidate: grant it.
  - IDLE, both candidates: grant the master the pointer selects, then toggle the pointer.
  - IDLE -> GNT0/GNT1 takes one cycle; the grant registers on the clock edge.
  - On the grant, push the master ID (0/1) into the ID FIFO.
  - GNT0/GNT1: SpMBUS_S/SpMVLD_S are a combinational mux of the granted master; granted SpMRDY_x = SpMRDY_S; the other SpMRDY = 0.
  - Return to IDLE on a handshake of a beat with EOP=1.
  - Minimum one idle cycle between packets.
- VLD from a master in IDLE without SOP: ignored and held off (RDY=0); not an error.
- FIFO full: no new grant. A pop in the same cycle does not unblock the grant until the next cycle. A packet already granted always completes.
- Response routing:
  - The head of the ID FIFO selects the destination master.
  - SpSVLD_x = SpSVLD_S for the head master only; SpSBUS_x carries SpSBUS_S to the head master; the other master's SpSBUS = 0.
  - SpSRDY_S = SpSRDY of the head master.
  - Pop the FIFO on a response handshake with EOP=1.
- FIFO empty while SpSVLD_S=1: SpSRDY_S = 1 (drain and discard); set ARB_ERR, which clears only on reset.
- Simultaneous push and pop: both take effect; the count is unchanged.
- The count uses $clog2(OUTSTANDING)+1 bits; read/write pointers wrap modulo OUTSTANDING.
- Latency: request path adds 1 cycle (grant) before the first beat, then 0-cycle pass-through. Response path is 0-cycle combinational.

Optional Feature:
- Macro: SPARTAN_ARB2_FIXED_PRI_EN.
- Defined: master 0 always wins simultaneous candidates; the pointer is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Single master: M0 sends a 3-beat packet (SOP on beat 1, EOP on beat 3), SpMRDY_S=1 -> one grant cycle, 3 beats appear on SpMBUS_S unchanged, FIFO count = 1; a 1-beat response with EOP -> delivered on SpSVLD_0 only, count = 0.
- Contention: both masters assert SOP every cycle for 4 single-beat packets each, responses returned immediately -> grants alternate 0,1,0,1...; with SPARTAN_ARB2_FIXED_PRI_EN, all four M0 packets go first.
- Backpressure: SpMRDY_S low for 5 cycles mid-packet -> SpMBUS_S held stable, no beat lost or duplicated, grant does not switch.
- Full: 4 packets issued with no responses -> the 5th SOP stalls with SpMRDY=0; one response popped -> the 5th packet is granted on the following cycle, never in the same cycle as the pop.
- Error: SpSVLD_S=1 with FIFO empty -> SpSRDY_S=1, ARB_ERR goes high and stays high; asserting RST mid-packet -> all outputs go to 0 at once and ARB_ERR clears.
